// File: rtl/fa_serial_seq.sv
// Bit-serial ripple adder sequencer: feeds one shared external full adder
// LSB first, one bit per cycle, and registers the WIDTH-bit result.
//
// state  | meaning
// S_IDLE | waiting for start; adder inputs held at 0; last result held
// S_RUN  | one operand bit per cycle presented to the adder
// S_DONE | one-cycle result-valid pulse; start ignored
module fa_serial_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [CW-1:0]    r_cnt;
  logic             w_last;
  logic [WIDTH-1:0] w_acc_shift;

  // Accumulator fills from the MSB so bit i ends up holding step i's sum.
  always_comb begin
    w_acc_shift            = r_acc >> 1;
    w_acc_shift[WIDTH-1]   = fa_sum;
  end

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    fa_a        = 1'b0;
    fa_b        = 1'b0;
    fa_cin      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        busy   = 1'b1;
        fa_a   = r_a_sh[0];
        fa_b   = r_b_sh[0];
        fa_cin = r_carry;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a_sh  <= op_a;
            r_b_sh  <= op_b;
            r_carry <= op_cin;
            r_acc   <= '0;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          r_a_sh  <= r_a_sh >> 1;
          r_b_sh  <= r_b_sh >> 1;
          r_acc   <= w_acc_shift;
          r_carry <= fa_cout;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_sum  <= w_acc_shift;
            r_cout <= fa_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_fa_serial_seq.sv
// Directed bench for fa_serial_seq: an 8-bit and a 1-bit instance, each
// wired to its own behavioural full adder.
module tb_fa_serial_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       op_cin;
  logic       fa_a, fa_b, fa_cin, fa_sum, fa_cout;
  logic       busy, done;
  logic [7:0] sum;
  logic       cout;

  logic       start1;
  logic [0:0] op_a1, op_b1;
  logic       op_cin1;
  logic       fa_a1, fa_b1, fa_cin1, fa_sum1, fa_cout1;
  logic       busy1, done1;
  logic [0:0] sum1;
  logic       cout1;

  int checks = 0;
  int errors = 0;

  fa_serial_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
    .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin),
    .fa_sum(fa_sum), .fa_cout(fa_cout),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  fa_serial_seq #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .op_a(op_a1), .op_b(op_b1), .op_cin(op_cin1),
    .fa_a(fa_a1), .fa_b(fa_b1), .fa_cin(fa_cin1),
    .fa_sum(fa_sum1), .fa_cout(fa_cout1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  // Shared external full adders.
  assign fa_sum   = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout  = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);
  assign fa_sum1  = fa_a1 ^ fa_b1 ^ fa_cin1;
  assign fa_cout1 = (fa_a1 & fa_b1) | (fa_a1 & fa_cin1) | (fa_b1 & fa_cin1);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0; op_a = 8'h00; op_b = 8'h00; op_cin = 1'b0;
    start1 = 1'b0; op_a1 = 1'b0; op_b1 = 1'b0; op_cin1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sum !== 8'h00 || cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_result: got sum=%h cout=%b, want sum=00 cout=0", sum, cout);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: got busy=%b done=%b, want 0 0", busy, done);
    end
    checks++;
    if (fa_a !== 1'b0 || fa_b !== 1'b0 || fa_cin !== 1'b0) begin
      errors++;
      $display("FAIL reset_fa: got fa_a=%b fa_b=%b fa_cin=%b, want 0 0 0", fa_a, fa_b, fa_cin);
    end
    checks++;
    if (sum1 !== 1'b0 || cout1 !== 1'b0 || busy1 !== 1'b0 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_w1: got sum=%b cout=%b busy=%b done=%b, want 0 0 0 0", sum1, cout1, busy1, done1);
    end
    rst_n = 1'b1;
  endtask

  task automatic run_add(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic [7:0] exp_sum, input logic exp_cout, input logic chk_cin);
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b; op_cin = cin;
    @(negedge clk);
    start = 1'b0; op_a = 8'hFF; op_b = 8'hFF; op_cin = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL run_hs step %0d: got busy=%b done=%b, want 1 0", i, busy, done);
      end
      checks++;
      if (fa_a !== a[i] || fa_b !== b[i]) begin
        errors++;
        $display("FAIL run_fa_ab step %0d: got %b%b, want %b%b", i, fa_a, fa_b, a[i], b[i]);
      end
      if (chk_cin && i >= 1) begin
        checks++;
        if (fa_cin !== 1'b1) begin
          errors++;
          $display("FAIL run_fa_cin step %0d: got %b, want 1", i, fa_cin);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_hs: got busy=%b done=%b, want 0 1", busy, done);
    end
    checks++;
    if (sum !== exp_sum || cout !== exp_cout) begin
      errors++;
      $display("FAIL result %h+%h+%b: got %b_%h, want %b_%h", a, b, cin, cout, sum, exp_cout, exp_sum);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || fa_a !== 1'b0 || fa_b !== 1'b0 || fa_cin !== 1'b0) begin
      errors++;
      $display("FAIL idle_after: got busy=%b done=%b fa=%b%b%b, want 0 0 000", busy, done, fa_a, fa_b, fa_cin);
    end
    checks++;
    if (sum !== exp_sum || cout !== exp_cout) begin
      errors++;
      $display("FAIL result_hold: got %b_%h, want %b_%h", cout, sum, exp_cout, exp_sum);
    end
    op_a = 8'h00; op_b = 8'h00; op_cin = 1'b0;
  endtask

  task automatic test_basic();
    run_add(8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0);
  endtask

  task automatic test_carry();
    run_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1);
    run_add(8'h7F, 8'h80, 1'b1, 8'h00, 1'b1, 1'b1);
  endtask

  // start held high; operands scrambled whenever the block is in RUN.
  task automatic test_back_to_back();
    int ndone;
    ndone = 0;
    @(negedge clk);
    start = 1'b1; op_a = 8'h12; op_b = 8'h34; op_cin = 1'b0;
    @(negedge clk);
    for (int t = 0; t < 30; t++) begin
      if ((t % 10) < 8) begin
        op_a = 8'hA5 ^ 8'(t); op_b = 8'h5A; op_cin = 1'b1;
      end else begin
        op_a = 8'h12; op_b = 8'h34; op_cin = 1'b0;
      end
      checks++;
      if (done !== ((t % 10) == 8)) begin
        errors++;
        $display("FAIL b2b_done t=%0d: got %b, want %b", t, done, ((t % 10) == 8));
      end
      if (done === 1'b1) begin
        ndone++;
        checks++;
        if (sum !== 8'h46 || cout !== 1'b0) begin
          errors++;
          $display("FAIL b2b_result t=%0d: got %b_%h, want 0_46", t, cout, sum);
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (ndone != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d done pulses, want 3", ndone);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    start = 1'b1; op_a = 8'h0F; op_b = 8'h01; op_cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
      errors++;
      $display("FAIL midrst: got busy=%b done=%b sum=%h cout=%b, want 0 0 00 0", busy, done, sum, cout);
    end
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL midrst_quiet t=%0d: got busy=%b done=%b, want 0 0", t, busy, done);
      end
    end
    run_add(8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_width1();
    @(negedge clk);
    start1 = 1'b1; op_a1 = 1'b1; op_b1 = 1'b1; op_cin1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; op_a1 = 1'b0; op_b1 = 1'b0; op_cin1 = 1'b0;
    checks++;
    if (busy1 !== 1'b1 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL w1_run: got busy=%b done=%b, want 1 0", busy1, done1);
    end
    @(negedge clk);
    checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b1 || sum1 !== 1'b1 || cout1 !== 1'b1) begin
      errors++;
      $display("FAIL w1_done: got busy=%b done=%b sum=%b cout=%b, want 0 1 1 1", busy1, done1, sum1, cout1);
    end
    @(negedge clk);
    checks++;
    if (done1 !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL w1_idle: got busy=%b done=%b, want 0 0", busy1, done1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_back_to_back();
    test_reset_mid_run();
    test_width1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fa_serial_seq.md
Name: fa_serial_seq

Overview:
- Sequencer that time-shares one external 1-bit full adder (3 inputs a/b/cin, 2 outputs sum/cout) to perform a WIDTH-bit ripple addition, one bit per cycle, LSB first.
- The block holds operand shift registers and the carry flop, and drives the adder's three inputs.
- It captures the adder's two outputs and presents the registered result with a start/busy/done handshake.
- Sits between a requesting datapath and a shared gate-level adder instance under test.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  request pulse/level; sampled only in IDLE
op_a  input  WIDTH  operand A, captured on accepted start
op_b  input  WIDTH  operand B, captured on accepted start
op_cin  input  1  carry-in, captured on accepted start
fa_a  output  1  to adder input A
fa_b  output  1  to adder input B
fa_cin  output  1  to adder carry-in
fa_sum  input  1  from adder sum output
fa_cout  input  1  from adder carry output
busy  output  1  high while in RUN
done  output  1  one-cycle pulse, result valid
sum  output  WIDTH  registered result
cout  output  1  registered final carry

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; operand, carry and counter registers cleared; sum=0, cout=0, busy=0, done=0.
  - Reset wins over every other event, including mid-RUN; any partial result is discarded and sum/cout read 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0; fa_a/fa_b/fa_cin driven 0.
  - On start=1: a_sh<=op_a, b_sh<=op_b, carry<=op_cin, cnt<=0, go to RUN.
  - sum/cout keep their previous result.
- RUN:
  - busy=1. Combinational drive: fa_a=a_sh[0], fa_b=b_sh[0], fa_cin=carry.
  - Each edge: a_sh, b_sh shift right with 0 fill; acc shifts right with fa_sum inserted at MSB; carry<=fa_cout; cnt<=cnt+1.
  - When cnt==WIDTH-1 at an edge: final shift occurs, sum<=shifted acc (bit i = fa_sum of step i), cout<=fa_cout, go to DONE.
  - start is ignored.
- DONE:
  - done=1, busy=0, fa_* driven 0.
  - Unconditionally go to IDLE next edge; start is ignored in this cycle.
  - sum/cout hold until the next accepted start completes or reset.
- Latency:
  - If start is accepted at edge n, busy is high for cycles n+1..n+WIDTH.
  - done is high for the single cycle following edge n+WIDTH.
  - Earliest next acceptance is edge n+WIDTH+2.
- Arithmetic: {cout,sum} == op_a + op_b + op_cin, modulo 2^(WIDTH+1); no overflow flag.
- Counter width is clog2(WIDTH) bits, minimum 1. For WIDTH=1, RUN lasts exactly one cycle.
- Adder timing: the adder is purely combinational and must settle within one cycle; fa_sum/fa_cout are sampled at every RUN edge.
- No X propagation: all outputs are defined in every state.

Test Plan:
- WIDTH=8, rst_n low 2 cycles -> sum=0x00, cout=0, busy=0, done=0, fa_a/fa_b/fa_cin=0.
- start with op_a=0x3C, op_b=0x05, op_cin=0 at edge n -> busy high cycles n+1..n+8; done pulse after edge n+8; sum=0x41, cout=0.
- op_a=0xFF, op_b=0x01, op_cin=0 -> sum=0x00, cout=1. Then op_a=0x7F, op_b=0x80, op_cin=1 -> sum=0x00, cout=1. Check fa_cin carries 1 from step 1 onward.
- start held high continuously, op_a=0x12, op_b=0x34 -> exactly one result per 10 cycles (sum=0x46); changing op_a/op_b during RUN has no effect on the result.
- Reset asserted at RUN cycle 4 -> next cycle is IDLE, sum=0, no done pulse. A subsequent 0xAA+0x55+1 yields sum=0x00, cout=1.
- WIDTH=1 build: op_a=1, op_b=1, op_cin=1 -> busy one cycle, done next cycle, sum=1, cout=1.
